// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// requester index encoding and the write-request record.
package regfile_wr_arbiter_pkg;

  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [0:0] {
    REQ_WB = 1'b0,
    REQ_LL = 1'b1
  } req_src_t;

  typedef struct packed {
    logic              valid;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_arb.sv
// Two-input round-robin arbiter: combinational one-hot grant, preference flops
// to the loser of every accepted grant so a waiting requester waits one cycle.
module rr_arb2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

  req_src_t pref;

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      if (pref == REQ_LL) grant1 = 1'b1;
      else                grant0 = 1'b1;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pref <= REQ_WB;
    end else if (accept) begin
      pref <= grant0 ? REQ_LL : REQ_WB;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between the WB stage and the
// long-latency unit, registered write port, and a busy scoreboard for decode.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int NREG = 1 << AW;

  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  req_src_t      win_src;
  req_src_t      rf_src;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_set;
  logic [NREG-1:0] busy_clr;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (accept),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // The output stage never stalls, so a grant is an accept.
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    win_src  = REQ_WB;
    if (grant1) begin
      win_addr = req1_addr;
      win_data = req1_data;
      win_src  = REQ_LL;
    end
  end

  // Writes to r0 are accepted and consume a turn but never reach the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_src   <= REQ_WB;
    end else begin
      rf_wen <= accept && (win_addr != '0);
      if (accept) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        rf_src   <= win_src;
      end
    end
  end

  // Clear retires on the edge that ends the req1 write cycle; a same-cycle
  // issue to that register re-arms it because set is applied after clear.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_valid && (iss_addr != '0))  busy_set[iss_addr] = 1'b1;
    if (rf_wen && (rf_src == REQ_LL))   busy_clr[rf_waddr] = 1'b1;
  end

  // NOTE: the scoreboard is reset because a stale busy bit would stall decode
  // forever; plain storage arrays without that meaning are left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~busy_clr) | busy_set;
  end

  assign q_busy1 = (q_addr1 != '0) && busy[q_addr1];
  assign q_busy2 = (q_addr2 != '0) && busy[q_addr2];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid, iss_valid;
  logic [4:0]  req0_addr, req1_addr, iss_addr, q_addr1, q_addr2;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, q_busy1, q_busy2, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: who is preferred, which registers are busy, and
  // what the registered write port shows this cycle.
  int          m_pref;
  bit          m_busy [NUM_REGS];
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_src;
  bit          acc0, acc1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pref  = 0;
    m_wen   = 0;
    m_waddr = '0;
    m_wdata = '0;
    m_src   = 0;
    for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
  endfunction

  function automatic int winner();
    if (req0_valid && req1_valid) return m_pref;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic compare_all();
    int w;
    w = winner();
    check("req0_ready", req0_ready, w == 0);
    check("req1_ready", req1_ready, w == 1);
    check("ready_onehot", req0_ready & req1_ready, 0);
    check("rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
    end
    check("q_busy1", q_busy1, (q_addr1 != 0) && m_busy[q_addr1]);
    check("q_busy2", q_busy2, (q_addr2 != 0) && m_busy[q_addr2]);
  endtask

  function automatic void model_edge();
    int w;
    logic [4:0] a;
    w = winner();
    if (m_wen && m_src == 1) m_busy[m_waddr] = 0;
    if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1;
    acc0 = (w == 0);
    acc1 = (w == 1);
    if (w >= 0) begin
      a       = (w == 1) ? req1_addr : req0_addr;
      m_pref  = 1 - w;
      m_wen   = (a != 0);
      m_waddr = a;
      m_wdata = (w == 1) ? req1_data : req0_data;
      m_src   = w;
    end else begin
      m_wen = 0;
    end
  endfunction

  // Checks the current cycle at the falling edge, then advances the model and
  // returns just after the next rising edge where stimulus is changed.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    iss_valid  = 0; iss_addr  = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b0;
    #1;
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  wr_req_t rq0, rq1;

  initial begin
    rst = 1'b0;
    q_addr1 = '0;
    q_addr2 = '0;
    clear_inputs();
    model_reset();
    reset_dut();

    // Single WB write, then idle.
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    cycle();
    clear_inputs();
    check("t1_wen", rf_wen, 1);
    check("t1_waddr", rf_waddr, 5);
    check("t1_wdata", rf_wdata, 32'hDEADBEEF);
    cycle();
    cycle();

    // Both requesters held valid: grants alternate starting from req0.
    reset_dut();
    req0_valid = 1; req0_addr = 3; req0_data = 32'h11;
    req1_valid = 1; req1_addr = 4; req1_data = 32'h22;
    #1;
    check("t2_first_grant", {req1_ready, req0_ready}, 2'b01);
    for (int i = 0; i < 4; i++) cycle();
    clear_inputs();
    cycle();

    // req1 to r0: accepted, no write, turn passes to req0.
    req1_valid = 1; req1_addr = 0; req1_data = 32'h5555;
    cycle();
    check("t3_no_wen", rf_wen, 0);
    req0_valid = 1; req0_addr = 2; req0_data = 32'h77;
    req1_valid = 1; req1_addr = 8; req1_data = 32'h88;
    #1;
    check("t3_pref_req0", {req1_ready, req0_ready}, 2'b01);
    cycle();
    clear_inputs();
    cycle();
    cycle();

    // Busy set by issue, kept through the req1 write cycle, cleared after;
    // a WB write to the same register leaves busy alone.
    q_addr1 = 7; q_addr2 = 9;
    iss_valid = 1; iss_addr = 7;
    cycle();
    clear_inputs();
    check("t4_busy_set", q_busy1, 1);
    req1_valid = 1; req1_addr = 7; req1_data = 32'hA7;
    cycle();
    clear_inputs();
    check("t4_busy_during_wr", q_busy1, 1);
    cycle();
    check("t4_busy_cleared", q_busy1, 0);
    iss_valid = 1; iss_addr = 7;
    cycle();
    clear_inputs();
    req0_valid = 1; req0_addr = 7; req0_data = 32'hB7;
    cycle();
    clear_inputs();
    cycle();
    cycle();
    check("t4_wb_keeps_busy", q_busy1, 1);

    // Issue to r9 in the very cycle its req1 write is on the port.
    iss_valid = 1; iss_addr = 9;
    cycle();
    clear_inputs();
    req1_valid = 1; req1_addr = 9; req1_data = 32'h99;
    cycle();
    clear_inputs();
    iss_valid = 1; iss_addr = 9;
    cycle();
    clear_inputs();
    cycle();
    check("t5_set_wins", q_busy2, 1);

    // Reset while a req1 write is in flight.
    q_addr1 = 6; q_addr2 = 9;
    iss_valid = 1; iss_addr = 6;
    cycle();
    clear_inputs();
    req1_valid = 1; req1_addr = 6; req1_data = 32'h66;
    cycle();
    clear_inputs();
    check("t6_inflight", rf_wen, 1);
    rst = 1'b0;
    #1;
    check("t6_async_wen", rf_wen, 0);
    check("t6_async_busy", {q_busy1, q_busy2}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic; requesters hold their request until accepted.
    rq0 = '0;
    rq1 = '0;
    for (int n = 0; n < 600; n++) begin
      if (!rq0.valid || acc0) begin
        rq0.valid = ($urandom_range(0, 9) < 6);
        rq0.addr  = 5'($urandom_range(0, 7));
        rq0.data  = $urandom;
      end
      if (!rq1.valid || acc1) begin
        rq1.valid = ($urandom_range(0, 9) < 6);
        rq1.addr  = 5'($urandom_range(0, 7));
        rq1.data  = $urandom;
      end
      req0_valid = rq0.valid; req0_addr = rq0.addr; req0_data = rq0.data;
      req1_valid = rq1.valid; req1_addr = rq1.addr; req1_data = rq1.data;
      iss_valid  = ($urandom_range(0, 9) < 3);
      iss_addr   = 5'($urandom_range(0, 7));
      q_addr1    = 5'($urandom_range(0, 7));
      q_addr2    = 5'($urandom_range(0, 7));
      acc0 = 0;
      acc1 = 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
